// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported unified memory between the instruction-fetch
//   port and the load/store data port of a 5-stage RV32I pipeline.
//   Data requests win over fetch requests (the MEM-stage instruction is
//   older). Each access is sequenced through IDLE -> FETCH/DATA/MISAL -> IDLE.
//   Stores get byte strobes and lane-replicated data; loads are shifted and
//   sign/zero extended. A stuck memory is aborted after TIMEOUT_CYCLES
//   request cycles and flagged with bus_err_o.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   if_req_i/if_addr_i      fetch request and address
//   if_rdata_o/if_valid_o   fetched word and one-cycle completion pulse
//   d_req_i, d_we_i, d_addr_i, d_wdata_i, d_store_type_i, d_load_type_i
//                           load/store request and attributes
//   d_rdata_o/d_valid_o     extended load data and one-cycle completion pulse
//   d_misalign_o            qualifies d_valid_o: access refused as misaligned
//   bus_err_o               one-cycle timeout flag, with the owner's valid
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
//                           registered memory request bus
//   mem_rdata_i/mem_ready_i memory read data and completion
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [1:0]  d_store_type_i,
    input  logic [2:0]  d_load_type_i,
    output logic [31:0] d_rdata_o,
    output logic        d_valid_o,
    output logic        d_misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2,
        S_MISAL = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        if_rdata_q;
    logic               if_valid_q;
    logic [31:0]        d_rdata_q;
    logic               d_valid_q;
    logic               d_misalign_q;
    logic               bus_err_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_wdata_q;
    logic [3:0]         mem_wstrb_q;

    logic [1:0]         st_size_s;
    logic [1:0]         ld_size_s;
    logic [1:0]         acc_size_s;
    logic               misal_d;
    logic [31:0]        wdata_d;
    logic [3:0]         wstrb_d;
    logic [31:0]        shifted_s;
    logic [31:0]        ld_data_d;
    logic               pulse_s;
    logic               timeout_s;

    // Decode access size, misalignment, store lanes and load extraction
    always_comb begin
        st_size_s  = SZ_WORD;
        ld_size_s  = SZ_WORD;
        misal_d    = 1'b0;
        wdata_d    = d_wdata_i;
        wstrb_d    = 4'b1111;
        shifted_s  = mem_rdata_i >> {d_addr_i[1:0], 3'b000};
        ld_data_d  = shifted_s;

        case (d_store_type_i)
            2'b01:   st_size_s = SZ_HALF;
            2'b10:   st_size_s = SZ_BYTE;
            default: st_size_s = SZ_WORD;
        endcase

        case (d_load_type_i)
            3'b001, 3'b011: ld_size_s = SZ_HALF;
            3'b010, 3'b111: ld_size_s = SZ_BYTE;
            default:        ld_size_s = SZ_WORD;
        endcase

        acc_size_s = d_we_i ? st_size_s : ld_size_s;

        case (acc_size_s)
            SZ_HALF: misal_d = d_addr_i[0];
            SZ_WORD: misal_d = |d_addr_i[1:0];
            default: misal_d = 1'b0;
        endcase

        case (st_size_s)
            SZ_BYTE: begin
                wdata_d = {4{d_wdata_i[7:0]}};
                wstrb_d = 4'b0001 << d_addr_i[1:0];
            end
            SZ_HALF: begin
                wdata_d = {2{d_wdata_i[15:0]}};
                wstrb_d = d_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_d = d_wdata_i;
                wstrb_d = 4'b1111;
            end
        endcase

        case (d_load_type_i)
            3'b001:  ld_data_d = {{16{shifted_s[15]}}, shifted_s[15:0]};
            3'b010:  ld_data_d = {{24{shifted_s[7]}},  shifted_s[7:0]};
            3'b011:  ld_data_d = {16'h0000, shifted_s[15:0]};
            3'b111:  ld_data_d = {24'h000000, shifted_s[7:0]};
            default: ld_data_d = shifted_s;
        endcase
    end

    // The cycle carrying a completion pulse is a dead IDLE cycle: requests
    // still high from the just-finished access must not be re-accepted.
    assign pulse_s   = if_valid_q | d_valid_q;
    assign timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Arbitration FSM with all outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            if_rdata_q   <= 32'h0000_0000;
            if_valid_q   <= 1'b0;
            d_rdata_q    <= 32'h0000_0000;
            d_valid_q    <= 1'b0;
            d_misalign_q <= 1'b0;
            bus_err_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            mem_wstrb_q  <= 4'b0000;
        end else begin
            if_valid_q   <= 1'b0;
            d_valid_q    <= 1'b0;
            d_misalign_q <= 1'b0;
            bus_err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!pulse_s && d_req_i) begin
                        if (misal_d) begin
                            state_q <= S_MISAL;
                        end else begin
                            state_q     <= S_DATA;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= d_we_i;
                            mem_addr_q  <= d_addr_i & 32'hFFFF_FFFC;
                            mem_wdata_q <= d_we_i ? wdata_d : 32'h0000_0000;
                            mem_wstrb_q <= d_we_i ? wstrb_d : 4'b0000;
                        end
                    end else if (!pulse_s && if_req_i) begin
                        state_q     <= S_FETCH;
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr_i & 32'hFFFF_FFFC;
                        mem_wdata_q <= 32'h0000_0000;
                        mem_wstrb_q <= 4'b0000;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FETCH, S_DATA: begin
                    if (mem_ready_i || timeout_s) begin
                        // Normal completion wins over a same-cycle timeout.
                        state_q     <= S_IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                        bus_err_q   <= ~mem_ready_i;
                        if (state_q == S_FETCH) begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= mem_ready_i ? mem_rdata_i : 32'h0000_0000;
                        end else begin
                            d_valid_q <= 1'b1;
                            d_rdata_q <= (mem_ready_i && !mem_we_q) ? ld_data_d
                                                                     : 32'h0000_0000;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_MISAL: begin
                    state_q      <= S_IDLE;
                    d_valid_q    <= 1'b1;
                    d_misalign_q <= 1'b1;
                    d_rdata_q    <= 32'h0000_0000;
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata_o   = if_rdata_q;
    assign if_valid_o   = if_valid_q;
    assign d_rdata_o    = d_rdata_q;
    assign d_valid_o    = d_valid_q;
    assign d_misalign_o = d_misalign_q;
    assign bus_err_o    = bus_err_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_wstrb_o  = mem_wstrb_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the instruction-fetch stage and the MEM-stage load/store unit of the 5-stage RV32I pipeline.
- Sequences each access through a small FSM and handles variable memory latency and bus timeout.
- Generates byte strobes and write-lane replication from the store-type code, and extracts and extends load data from the load-type code.
- Drives per-port valid pulses that the hazard logic uses to stall IF and MEM.

Parameters:
- TIMEOUT_CYCLES, 64: maximum number of cycles mem_req may stay high without mem_ready before the access is aborted.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high with if_addr stable until if_valid
- if_addr  in  32  fetch address; bits [1:0] ignored
- if_rdata  out  32  fetched instruction; valid only while if_valid=1
- if_valid  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held high with all d_* inputs stable until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  byte address
- d_wdata  in  32  store data, right-aligned
- d_store_type  in  2  00 word, 01 half, 10 byte, 11 treated as word
- d_load_type  in  3  000 word, 001 half, 010 byte, 011 half unsigned, 111 byte unsigned; other codes treated as word
- d_rdata  out  32  extended load result; valid only while d_valid=1
- d_valid  out  1  one-cycle data completion pulse
- d_misalign  out  1  qualifies d_valid: access was misaligned and not performed
- bus_err  out  1  one-cycle pulse on timeout; coincides with the if_valid or d_valid of the aborted access
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables; 0000 on reads
- mem_rdata  in  32  read data; valid in the cycle mem_ready=1
- mem_ready  in  1  completion; sampled only while mem_req=1

Behaviour:
- Reset: state IDLE. mem_req, mem_we, if_valid, d_valid, d_misalign, bus_err all 0. mem_wstrb 0000. mem_addr, mem_wdata, if_rdata, d_rdata all 0. Timeout counter 0.
- FSM states: IDLE, FETCH, DATA, MISAL.
- IDLE arbitration is fixed priority: data wins over fetch, because the MEM-stage instruction is older.
  - d_req with an aligned access -> DATA.
  - d_req with a misaligned access -> MISAL.
  - Otherwise if_req -> FETCH.
  - The mem_* outputs are registered on that same edge, so mem_req is high the cycle after acceptance.
- Misalignment rule:
  - half access with addr[0]=1 is misaligned.
  - word access with addr[1:0]≠00 is misaligned.
  - For loads, use the d_load_type size; for stores, use the d_store_type size.
- FETCH / DATA:
  - mem_req is held with mem_addr, mem_we, mem_wdata and mem_wstrb stable until mem_ready=1.
  - On the mem_ready edge: capture and extend the read data into if_rdata or d_rdata, pulse the matching valid for the next cycle, drop mem_req, and return to IDLE.
- Latency: request sampled at edge 0 -> mem_req high in cycle 1.
  - With mem_ready=1 in cycle 1, the valid pulse appears in cycle 2.
  - Minimum latency is 2 cycles; each memory wait cycle adds 1.
- MISAL: lasts one cycle with no memory access. Next cycle d_valid=1, d_misalign=1, d_rdata=0. Then back to IDLE.
- Re-arbitration:
  - Returning to IDLE costs one cycle, so back-to-back accesses are spaced 3 cycles apart minimum.
  - A request still high in the valid-pulse cycle is not re-accepted. Requesters must drop or change req on the cycle after valid.
- Store lanes, with o = addr[1:0]:
  - byte: mem_wdata = {4{wdata[7:0]}}, mem_wstrb = 0001<<o.
  - half: mem_wdata = {2{wdata[15:0]}}, mem_wstrb = 0011 when o=00, 1100 when o=10.
  - word: mem_wdata = wdata, mem_wstrb = 1111.
- Load extract:
  - Shift mem_rdata right by 8*o, then sign-extend (byte, half) or zero-extend (byte_u, half_u) from bit 7 or bit 15.
  - Stores return d_rdata = 0 with d_valid.
- Timeout:
  - The counter clears on every transition into FETCH or DATA and increments each cycle mem_req=1 and mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES-1 and mem_ready is still 0: drop mem_req, pulse the owner's valid with rdata=0 plus bus_err=1, and go to IDLE.
  - If mem_ready=1 in that same cycle, it completes normally and bus_err stays 0.
- Simultaneous d_req and if_req in IDLE: data is served first and fetch waits. Fetch can starve only while d_req is continuously reasserted, which the pipeline cannot do because a MEM stall freezes IF.
- Reset mid-transaction: mem_req drops at the reset edge and no valid pulse is generated. The memory model must tolerate the abandoned request.
- if_valid and d_valid are never high in the same cycle.

Test Plan:
- Zero-wait fetch: if_req, if_addr=0x0000_0104, mem_ready=1 in the first req cycle, mem_rdata=0x0010_0093 -> mem_addr=0x104, if_valid in cycle 2, if_rdata=0x0010_0093.
- Contention: d_req (LW, 0x200) and if_req in the same cycle, with 3 wait states -> data served first, d_valid at cycle 5, then fetch issued in the following cycle.
- Signed and unsigned loads from mem_rdata=0x80F0_7F81:
  - LB at addr 0x3 -> 0xFFFF_FF80.
  - LBU at addr 0x3 -> 0x0000_0080.
  - LH at addr 0x2 -> 0xFFFF_80F0.
  - LHU at addr 0x2 -> 0x0000_80F0.
- Stores:
  - SB wdata=0x1234_56AB at addr 0x2 -> mem_wdata=0xABAB_ABAB, mem_wstrb=0100.
  - SH at addr 0x2 -> mem_wdata=0x56AB_56AB, mem_wstrb=1100.
- Misalign: LW at addr 0x6 -> no mem_req, d_valid=1 with d_misalign=1 two cycles after the request; SH at addr 0x1 -> same behaviour.
- Timeout and reset:
  - mem_ready held 0 -> after 64 cycles, bus_err=1 with d_valid, mem_req=0.
  - rst asserted at wait cycle 3 -> mem_req=0 next cycle, no valid pulse, state IDLE.
